data_mem_responder: RTL
=======================

# data_mem_responder

Memory-side responder for the multi-cycle core's load/store path. Accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. It performs little-endian byte, half and word accesses on a 256×32 word array, returning sign- or zero-extended load data. Misaligned or illegal accesses are flagged with an error response. It sits between the core's load/store control and the data RAM, replacing the direct single-cycle RAM hookup.

## Interface
- `ADDR_W`, default 10: byte-address width; word index is `addr[ADDR_W-1:2]`.
- `WAIT`, default 2: wait-state cycles between accept and response; range 0–15.
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: responder can accept a request.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_addr`, in, ADDR_W: byte address.
- `req_funct3`, in, 3: RV32I width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_wdata`, in, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`, out, 1: one-cycle response strobe.
- `rsp_rdata`, out, 32: formatted load data; 0 for stores and errors.
- `rsp_err`, out, 1: access error; valid only with `rsp_valid`.
- `busy`, out, 1: a request is in flight (state ≠ IDLE).

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - If `req_valid` is high on an edge, capture we/addr/funct3/wdata and load the wait counter with WAIT.
  - Go to WAIT, or directly to RESP if WAIT=0.
- **WAIT**
  - Counter decrements each cycle.
  - When the counter reaches 1, go to RESP on the next edge.
  - `req_valid` is ignored here.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle, then return to IDLE.
  - No response back-pressure: the core must take the response in that cycle.
- **Error check** (evaluated on the captured request):
  - Illegal funct3: 011/110/111 for any access, or 100/101 for a store.
  - Misaligned: half access with `addr[0]`≠0; word access with `addr[1:0]`≠0.
  - On error: `rsp_err`=1, no memory write, `rsp_rdata`=0.
- **Store**
  - Byte-lane write on the edge entering RESP.
  - Lane select = `addr[1:0]`, little-endian.
  - SB writes one lane, SH writes lanes {1,0} or {3,2}, SW writes all four.
  - Other lanes are unchanged.
- **Load**
  - Word read on the edge entering RESP.
  - The selected lane is extracted and formatted: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Result appears on `rsp_rdata` during RESP.
- **Read-after-write:** a load accepted after a store's RESP cycle returns the new data.
- Memory contents are not cleared by reset.

## Timing
- Reset values:
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0.
  - FSM in IDLE, counter=0.
- Latency: `rsp_valid` is high in the cycle beginning WAIT+1 edges after the accepting edge.
- `req_ready` deasserts the cycle after accept and reasserts the cycle after RESP.
- Throughput: one request per WAIT+2 cycles.
- `rsp_rdata` and `rsp_err` are registered. They hold their values outside RESP but are meaningful only with `rsp_valid`.
- Reset mid-operation drops the pending request. If `rst` falls before the write edge, the store is not performed and no response is issued.
- A request presented during RESP is not accepted. It is accepted in the following IDLE cycle if still valid.

## Structure
- Shared package `mem_pkg`:
  - funct3 width codes
  - FSM state encoding (2-bit)
  - `MEM_WORDS`=256
- Sub-module `mem_load_fmt`: combinational lane extract plus sign/zero extension.
  - Inputs: word, `addr[1:0]`, funct3.
  - Output: 32-bit formatted data.
- The top level holds the FSM, counter, request registers, memory array and byte-lane write logic.

## Test plan
- **SW then LW, WAIT=2:** SW 0xDEADBEEF @0x010, then LW @0x010.
  - Each response arrives 3 cycles after accept.
  - LW returns 0xDEADBEEF with `rsp_err`=0.
- **Byte stores and signed/unsigned byte loads:** SB 0x80 @0x013, then LB @0x013 and LBU @0x013.
  - LB returns 0xFFFFFF80; LBU returns 0x00000080.
  - Word @0x010 reads 0x80ADBEEF.
- **Half loads:** SH 0x7FFE @0x012, then LH @0x012.
  - Returns 0x00007FFE.
  - LHU @0x010 returns 0x0000BEEF.
- **Misaligned and illegal accesses:** LW @0x011, SH @0x015, funct3=011.
  - Each gets `rsp_err`=1 and `rsp_rdata`=0.
  - A following LW @0x014 shows the memory unchanged.
- **Handshake:** hold `req_valid` high continuously with WAIT=0.
  - Accepts occur every 2 cycles.
  - `req_ready` is low exactly in RESP; `busy` is high exactly in RESP.
- **Reset mid-operation:** assert `rst` low during WAIT of SW 0x12345678 @0x020.
  - No `rsp_valid` is issued.
  - A later LW @0x020 returns the previous contents.
  - All outputs are at their reset values while `rst` is low.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: width codes, FSM encoding,
// memory depth and the access-legality check.
package mem_pkg;

    localparam int MEM_WORDS = 256;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // 1 when the width code is illegal for the direction or the address is misaligned.
    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic err;
        err = 1'b0;
        case (f3)
            F3_B:         err = 1'b0;
            F3_H:         err = lo[0];
            F3_W:         err = (lo != 2'b00);
            F3_BU:        err = we;
            F3_HU:        err = we | lo[0];
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// Load formatter: picks the addressed byte/half lane out of a word and
// sign- or zero-extends it according to the load width code.
module mem_load_fmt
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        data = '0;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_W:    data = word;
            F3_BU:   data = {24'd0, byte_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder for the multi-cycle core: one request at a time,
// programmable wait states, byte/half/word accesses on a 256x32 array.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; accept on req_valid
// ST_WAIT | counting down wait states for the captured request
// ST_RESP | one-cycle response strobe, memory already read/written
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;

    logic              accept;
    logic              enter_resp;
    logic              eff_we;
    logic [ADDR_W-1:0] eff_addr;
    logic [2:0]        eff_f3;
    logic [31:0]       eff_wdata;
    logic              eff_err;
    logic [3:0]        byte_en;
    logic [31:0]       lane_wdata;
    logic [31:0]       rd_word;
    logic [31:0]       fmt_data;

    logic [31:0]       mem [MEM_WORDS];

    assign accept     = (state == ST_IDLE) && req_valid;
    assign enter_resp = (state_nxt == ST_RESP) && (state != ST_RESP);

    // With WAIT=0 the response edge is the accept edge, so use the live request then.
    assign eff_we    = accept ? req_we     : we_q;
    assign eff_addr  = accept ? req_addr   : addr_q;
    assign eff_f3    = accept ? req_funct3 : f3_q;
    assign eff_wdata = accept ? req_wdata  : wdata_q;
    assign eff_err   = access_err(eff_we, eff_f3, eff_addr[1:0]);

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_nxt   = WAIT_CNT;
                    state_nxt = (WAIT_CNT == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_en    = 4'b0000;
        lane_wdata = eff_wdata;
        case (eff_f3)
            F3_B: begin
                byte_en    = 4'b0001 << eff_addr[1:0];
                lane_wdata = {4{eff_wdata[7:0]}};
            end
            F3_H: begin
                byte_en    = eff_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{eff_wdata[15:0]}};
            end
            F3_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    assign rd_word = mem[eff_addr[ADDR_W-1:2]];

    mem_load_fmt u_fmt (
        .word    (rd_word),
        .addr_lo (eff_addr[1:0]),
        .funct3  (eff_f3),
        .data    (fmt_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            f3_q      <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                f3_q    <= req_funct3;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                rsp_err   <= eff_err;
                rsp_rdata <= (eff_err || eff_we) ? 32'd0 : fmt_data;
            end
        end
    end

    // Array is deliberately not reset; rst gating keeps a store from landing while reset is held.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && eff_we && !eff_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[eff_addr[ADDR_W-1:2]][8*i +: 8] <= lane_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
